pc_sequencer: RTL and testbench

//  Fetch/issue controller for the CPU core. It replaces the bare program counter and its enable glue.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/hazard_scoreboard.sv | 45 ++++
 rtl/pc_sequencer.sv | 120 ++++++++++++
 tb/tb_pc_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and defaults for the fetch/issue sequencer
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } seq_state_t;

  localparam int WB_LATENCY_DEFAULT = 2;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight register writes and read-after-write hazard detection
module hazard_scoreboard #(
  parameter int REG_ADDR_WIDTH = 2,
  parameter int WB_LATENCY     = 2
) (
  input  logic                      clk,
  input  logic                      n_reset,
  input  logic                      push_valid,
  input  logic [REG_ADDR_WIDTH-1:0] push_addr,
  input  logic                      rd_used_a,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_a,
  input  logic                      rd_used_b,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_b,
  output logic                      haz
);

  logic [WB_LATENCY-1:0]     sb_valid;
  logic [REG_ADDR_WIDTH-1:0] sb_addr [WB_LATENCY];

  // Entry i holds the write issued i+1 cycles ago; it is visible until it retires.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sb_valid <= '0;
      for (int i = 0; i < WB_LATENCY; i++) sb_addr[i] <= '0;
    end else begin
      sb_valid[0] <= push_valid;
      sb_addr[0]  <= push_addr;
      for (int i = 1; i < WB_LATENCY; i++) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_addr[i]  <= sb_addr[i-1];
      end
    end
  end

  // Register file reads return the old value on a same-cycle write, so every entry counts.
  always_comb begin
    haz = 1'b0;
    for (int i = 0; i < WB_LATENCY; i++) begin
      if (sb_valid[i] && ((rd_used_a && (rd_addr_a == sb_addr[i])) ||
                          (rd_used_b && (rd_addr_b == sb_addr[i]))))
        haz = 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter, issue/bubble decision, wait/halt FSM, stall counter
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int INSTR_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH   = 2,
  parameter int WB_LATENCY       = WB_LATENCY_DEFAULT,
  parameter int STALL_CNT_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        n_reset,
  input  logic                        ready_in,
  input  logic                        f_wait,
  input  logic                        wait_edge,
  input  logic                        wait_pol,
  input  logic                        f_jump,
  input  logic [INSTR_ADDR_WIDTH-1:0] jump_addr,
  input  logic                        f_halt,
  input  logic                        rd_used_a,
  input  logic                        rd_used_b,
  input  logic [REG_ADDR_WIDTH-1:0]   rd_addr_a,
  input  logic [REG_ADDR_WIDTH-1:0]   rd_addr_b,
  input  logic                        wr_res,
  input  logic [REG_ADDR_WIDTH-1:0]   wr_addr,
  output logic [INSTR_ADDR_WIDTH-1:0] pc,
  output logic                        issue,
  output logic                        halted,
  output logic [STALL_CNT_WIDTH-1:0]  stall_count
);

  seq_state_t                  state, state_nxt;
  logic [INSTR_ADDR_WIDTH-1:0] pc_nxt;
  logic                        ready_p;
  logic                        haz;
  logic                        cond;
  logic                        wait_met;
  logic                        stall;

  hazard_scoreboard #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .WB_LATENCY     (WB_LATENCY)
  ) u_scoreboard (
    .clk        (clk),
    .n_reset    (n_reset),
    .push_valid (issue & wr_res),
    .push_addr  (wr_addr),
    .rd_used_a  (rd_used_a),
    .rd_addr_a  (rd_addr_a),
    .rd_used_b  (rd_used_b),
    .rd_addr_b  (rd_addr_b),
    .haz        (haz)
  );

  assign cond     = wait_edge ? (!ready_p && ready_in) : ready_in;
  assign wait_met = (cond == wait_pol);
  assign halted   = (state == HALT);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    issue     = 1'b0;
    stall     = 1'b0;
    unique case (state)
      RUN: begin
        if (haz) begin
          stall = 1'b1;
        end else if (f_halt) begin
          issue     = 1'b1;
          state_nxt = HALT;
        end else if (f_wait) begin
          if (wait_met) begin
            issue  = 1'b1;
            pc_nxt = pc + 1'b1;
          end else begin
            stall     = 1'b1;
            state_nxt = WAIT;
          end
        end else if (f_jump) begin
          issue  = 1'b1;
          pc_nxt = jump_addr;
        end else begin
          issue  = 1'b1;
          pc_nxt = pc + 1'b1;
        end
      end
      WAIT: begin
        if (wait_met) begin
          issue     = 1'b1;
          pc_nxt    = pc + 1'b1;
          state_nxt = RUN;
        end else begin
          stall = 1'b1;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
    // Keeps the scoreboard push and the datapath quiet while reset is held.
    if (!n_reset) issue = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state       <= RUN;
      pc          <= '0;
      ready_p     <= 1'b1;
      stall_count <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      ready_p <= ready_in;
      if (stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer against a timeline reference model
module tb_pc_sequencer;
  localparam int IAW = 4;
  localparam int RAW = 2;
  localparam int WBL = 2;
  localparam int SCW = 8;
  localparam int SAT = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           n_reset, ready_in, f_wait, wait_edge, wait_pol, f_jump, f_halt;
  logic           rd_used_a, rd_used_b, wr_res;
  logic [IAW-1:0] jump_addr;
  logic [RAW-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [IAW-1:0] pc;
  logic           issue, halted;
  logic [SCW-1:0] stall_count;

  pc_sequencer #(
    .INSTR_ADDR_WIDTH (IAW),
    .REG_ADDR_WIDTH   (RAW),
    .WB_LATENCY       (WBL),
    .STALL_CNT_WIDTH  (SCW)
  ) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .ready_in    (ready_in),
    .f_wait      (f_wait),
    .wait_edge   (wait_edge),
    .wait_pol    (wait_pol),
    .f_jump      (f_jump),
    .jump_addr   (jump_addr),
    .f_halt      (f_halt),
    .rd_used_a   (rd_used_a),
    .rd_used_b   (rd_used_b),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .wr_res      (wr_res),
    .wr_addr     (wr_addr),
    .pc          (pc),
    .issue       (issue),
    .halted      (halted),
    .stall_count (stall_count)
  );

  typedef struct {
    string tag;
    int    pc;
    int    issue;
    int    halted;
    int    stalls;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: a register is unreadable until WB_LATENCY+1 cycles after its writer issues.
  int m_pc, m_stalls, cyc;
  bit m_wait, m_halt, m_rp;
  int busy_until [4];

  function automatic void model_reset();
    m_pc = 0; m_stalls = 0; m_wait = 0; m_halt = 0; m_rp = 1;
    for (int r = 0; r < 4; r++) busy_until[r] = 0;
  endfunction

  function automatic void chk(string tag, string what, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s %s: got %0d want %0d (t=%0t)", tag, what, act, req, $time);
    end
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk(e.tag, "pc", int'(pc), e.pc);
        chk(e.tag, "issue", int'(issue), e.issue);
        chk(e.tag, "halted", int'(halted), e.halted);
        chk(e.tag, "stall_count", int'(stall_count), e.stalls);
      end
    end
  end

  task automatic clr();
    f_wait = 0; wait_edge = 0; wait_pol = 0; f_jump = 0; jump_addr = '0; f_halt = 0;
    rd_used_a = 0; rd_used_b = 0; rd_addr_a = '0; rd_addr_b = '0; wr_res = 0; wr_addr = '0;
  endtask

  task automatic cycle(string tag);
    exp_t e;
    bit   cond, met, iss, bub, hz;
    int   npc;
    e.tag = tag; e.pc = m_pc; e.halted = int'(m_halt); e.stalls = m_stalls;
    iss = 0; bub = 0; npc = m_pc;
    if (!n_reset) begin
      e.issue = 0;
      exp_q.push_back(e);
      model_reset();
    end else begin
      cond = wait_edge ? (!m_rp && ready_in) : ready_in;
      met  = (cond == wait_pol);
      hz   = (rd_used_a && cyc < busy_until[rd_addr_a]) || (rd_used_b && cyc < busy_until[rd_addr_b]);
      if (!m_halt) begin
        if (m_wait) begin
          if (met) begin iss = 1; npc = m_pc + 1; m_wait = 0; end
          else bub = 1;
        end else if (hz) bub = 1;
        else if (f_halt) begin iss = 1; m_halt = 1; end
        else if (f_wait) begin
          if (met) begin iss = 1; npc = m_pc + 1; end
          else begin bub = 1; m_wait = 1; end
        end else if (f_jump) begin iss = 1; npc = int'(jump_addr); end
        else begin iss = 1; npc = m_pc + 1; end
      end
      e.issue = int'(iss);
      exp_q.push_back(e);
      if (iss && wr_res) busy_until[wr_addr] = cyc + WBL + 1;
      m_pc = npc % (1 << IAW);
      if (bub && m_stalls < SAT) m_stalls++;
      m_rp = ready_in;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    int sel;
    clr();
    sel = $urandom_range(0, 63);
    f_halt    = (sel == 0);
    f_wait    = (sel >= 1 && sel <= 8);
    f_jump    = (sel >= 9 && sel <= 16);
    jump_addr = IAW'($urandom);
    wait_edge = 1'($urandom);
    wait_pol  = 1'($urandom);
    ready_in  = 1'($urandom);
    rd_used_a = 1'($urandom);
    rd_used_b = 1'($urandom);
    rd_addr_a = RAW'($urandom);
    rd_addr_b = RAW'($urandom);
    wr_res    = 1'($urandom);
    wr_addr   = RAW'($urandom);
    n_reset   = ($urandom_range(0, 99) != 0);
  endtask

  initial begin : stim
    clr();
    n_reset = 0; ready_in = 1; cyc = 0;
    @(posedge clk);
    #1;
    model_reset();

    repeat (3) cycle("t1_reset");
    n_reset = 1;
    cycle("t1_release");

    clr(); n_reset = 0; cycle("t2_rst"); n_reset = 1;
    wr_res = 1; wr_addr = 2; cycle("t2_writer");
    clr(); rd_used_a = 1; rd_addr_a = 2;
    repeat (4) cycle("t2_reader");

    clr(); f_wait = 1; wait_edge = 0; wait_pol = 1; ready_in = 0;
    repeat (5) cycle("t3_level_wait");
    ready_in = 1; cycle("t3_release");
    clr(); cycle("t3_after");

    f_wait = 1; wait_edge = 1; wait_pol = 1; ready_in = 1;
    repeat (4) cycle("t4_no_edge");
    ready_in = 0; repeat (2) cycle("t4_low");
    ready_in = 1; cycle("t4_edge");
    clr(); cycle("t4_after");

    f_jump = 1; jump_addr = 4'hF; cycle("t5_jump");
    clr(); cycle("t5_wrap");
    f_halt = 1; cycle("t5_halt");
    clr();
    for (int i = 0; i < 6; i++) begin
      rand_inputs(); n_reset = 1; cycle("t5_halted");
    end

    clr(); n_reset = 0; cycle("t6_rst"); n_reset = 1;
    f_wait = 1; wait_edge = 0; wait_pol = 1; ready_in = 0;
    repeat (300) cycle("t6_saturate");
    n_reset = 0; cycle("t6_reset_mid_wait");
    n_reset = 1; clr(); ready_in = 1; cycle("t6_after_reset");

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle("random");
    end

    @(negedge clk);
    #1;
    chk("end", "pending_expectations", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
